alu_writeback_stage: RTL

//  Registered writeback stage directly downstream of the 8-bit ALU.

---
 rtl/alu_writeback_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - ALU writeback stage: 2-entry skid buffer, flag registers, sticky exception
// Optional exception counter enabled by defining EXC_COUNT_EN.
module alu_writeback_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_result,
  input  logic [1:0]        in_overflow,
  input  logic              in_zf,
  input  logic              in_exp,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic              wb_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        flag_ov,
  output logic              flag_z,
  output logic              exc_pending,
  input  logic              exc_clear,
  output logic [7:0]        exc_count
);

  typedef enum logic {ST_RUN = 1'b0, ST_EXCEPT = 1'b1} state_t;

  state_t state, state_nx;

  logic [2:0]        buf_op     [2];
  logic [DATA_W-1:0] buf_result [2];
  logic [1:0]        buf_ov     [2];
  logic              buf_zf     [2];
  logic              buf_exp    [2];
  logic [ADDR_W-1:0] buf_waddr  [2];

  logic       wr_ptr, rd_ptr;
  logic [1:0] count;

  logic head, accept, drain, exc_detect, head_writes, head_sets_flags;

  assign head       = (count != 2'd0);
  assign in_ready   = (state == ST_RUN) && (count != 2'd2);
  assign accept     = in_valid && in_ready;
  assign exc_detect = head && (state == ST_RUN) && buf_exp[rd_ptr];
  assign drain      = head && (state == ST_RUN) && !wb_stall && !buf_exp[rd_ptr];

  // Ops 101..111 retire without touching the register file or flags
  assign head_writes     = (buf_op[rd_ptr] <= 3'b100);
  assign head_sets_flags = (buf_op[rd_ptr] == 3'b000) || (buf_op[rd_ptr] == 3'b100);

  assign wr_en   = drain && head_writes;
  assign wr_addr = wr_en ? buf_waddr[rd_ptr]  : '0;
  assign wr_data = wr_en ? buf_result[rd_ptr] : '0;

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:    if (exc_detect) state_nx = ST_EXCEPT;
      ST_EXCEPT: if (exc_clear)  state_nx = ST_RUN;
      default:   state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_RUN;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      flag_ov     <= 2'b00;
      flag_z      <= 1'b0;
      exc_pending <= 1'b0;
    end else begin
      state <= state_nx;
      if (exc_detect) begin
        // Flush drops the faulting head, its neighbour and any same-cycle accept
        wr_ptr      <= 1'b0;
        rd_ptr      <= 1'b0;
        count       <= 2'd0;
        exc_pending <= 1'b1;
      end else if (state == ST_EXCEPT) begin
        if (exc_clear) exc_pending <= 1'b0;
      end else begin
        if (accept) begin
          buf_op[wr_ptr]     <= in_op;
          buf_result[wr_ptr] <= in_result;
          buf_ov[wr_ptr]     <= in_overflow;
          buf_zf[wr_ptr]     <= in_zf;
          buf_exp[wr_ptr]    <= in_exp;
          buf_waddr[wr_ptr]  <= in_waddr;
          wr_ptr             <= ~wr_ptr;
        end
        if (drain) begin
          rd_ptr <= ~rd_ptr;
          if (head_sets_flags) begin
            flag_ov <= buf_ov[rd_ptr];
            flag_z  <= buf_zf[rd_ptr];
          end
        end
        case ({accept, drain})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef EXC_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset)
      exc_count <= 8'h00;
    else if (exc_detect && exc_count != 8'hFF)
      exc_count <= exc_count + 8'h01;
  end
`else
  assign exc_count = 8'h00;
`endif

endmodule
